// File: rtl/divider_pkg.sv
// Shared constants for the sequential non-restoring divider: default width and
// the controller-to-datapath operand select encoding.
package divider_pkg;

  localparam int DIV_WIDTH = 16;

  // Operand select for the add path: +D, -D, or +0.
  localparam logic [1:0] SEL_ADD  = 2'b00;
  localparam logic [1:0] SEL_SUB  = 2'b01;
  localparam logic [1:0] SEL_ZERO = 2'b10;

endpackage

// File: rtl/divider_addsub.sv
// WIDTH+1 bit adder for the partial remainder. Subtraction is done by inverting
// the zero-extended divisor and injecting a carry-in.
module divider_addsub
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0] operand;
  logic           carry_in;

  always_comb begin
    operand  = '0;
    carry_in = 1'b0;
    case (sel)
      SEL_ADD: operand = {1'b0, d};
      SEL_SUB: begin
        operand  = ~{1'b0, d};
        carry_in = 1'b1;
      end
      default: operand = '0;
    endcase
  end

  // Arithmetic wraps at 2^(WIDTH+1); the remainder register is two's complement.
  assign sum = a + operand + {{WIDTH{1'b0}}, carry_in};

endmodule

// File: rtl/divider_datapath.sv
// Datapath slave of the sequential non-restoring divider: remainder/quotient/divisor
// registers driven by per-cycle controller commands, plus a registered result port.
module divider_datapath
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             add,
  input  logic             shift,
  input  logic             inbit,
  input  logic [1:0]       sel,
  input  logic             valid,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             sign,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             result_valid
);

  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;

  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] d_next;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_sum;

  // The adder sees the shifted remainder when shift and add coincide.
  assign shifted = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign add_a   = shift ? shifted : r_q;

  divider_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a   (add_a),
    .d   (d_q),
    .sel (sel),
    .sum (add_sum)
  );

  always_comb begin
    r_next = r_q;
    q_next = q_q;
    d_next = d_q;
    if (load) begin
      r_next = '0;
      q_next = dividend;
      d_next = divisor;
    end else begin
      if (add) begin
        r_next = add_sum;
      end else if (shift) begin
        r_next = shifted;
      end
      if (shift) begin
        q_next = {q_q[WIDTH-2:0], inbit};
      end
    end
  end

  // Result handshake: valid is a one-cycle strobe with no back-pressure. On the
  // strobe edge the pre-update Q/R are captured, and result_valid pulses for
  // exactly the following cycle; quotient/remainder then hold until the next strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q          <= '0;
      q_q          <= '0;
      d_q          <= '0;
      quotient     <= '0;
      remainder    <= '0;
      result_valid <= 1'b0;
    end else begin
      r_q          <= r_next;
      q_q          <= q_next;
      d_q          <= d_next;
      result_valid <= valid;
      if (valid) begin
        quotient  <= q_q;
        remainder <= r_q[WIDTH-1:0];
      end
    end
  end

  assign sign = r_q[WIDTH];

endmodule
